// File: rtl/if_stage_ifid.sv
// ============================================================================
// Module   : if_stage_ifid
// Purpose  : MIPS instruction-fetch stage (PC owner) plus IF/ID register.
//            Optional stall/flush counters when IF_PERF_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage_ifid #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_IFWrite,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  input  logic        IMemReady,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        FetchWait
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] IfStallCnt,
  output logic [31:0] IfFlushCnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_ifidPc;
  logic [31:0] r_ifidPcPlus4;
  logic        r_valid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pcPlus4;

  assign w_redirect = BranchTaken | JumpTaken;
  // The branch sits in EX and is older than the jump in ID, so it wins.
  assign w_target   = BranchTaken ? {BranchTarget[31:2], 2'b00}
                                  : {JumpTarget[31:2], 2'b00};
  assign w_pcPlus4  = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_ifidPc      <= 32'd0;
      r_ifidPcPlus4 <= 32'd0;
      r_valid       <= 1'b0;
    end else if (w_redirect) begin
      r_pc          <= w_target;
      r_instr       <= NOP_INSTR;
      r_ifidPc      <= 32'd0;
      r_ifidPcPlus4 <= 32'd0;
      r_valid       <= 1'b0;
    end else if (!PC_IFWrite) begin
      r_pc          <= r_pc;
    end else if (!IMemReady) begin
      r_instr       <= NOP_INSTR;
      r_ifidPc      <= 32'd0;
      r_ifidPcPlus4 <= 32'd0;
      r_valid       <= 1'b0;
    end else begin
      r_pc          <= w_pcPlus4;
      r_instr       <= IMemData;
      r_ifidPc      <= r_pc;
      r_ifidPcPlus4 <= w_pcPlus4;
      r_valid       <= 1'b1;
    end
  end

  assign IMemAddr      = r_pc;
  assign IF_ID_Instr   = r_instr;
  assign IF_ID_PC      = r_ifidPc;
  assign IF_ID_PCPlus4 = r_ifidPcPlus4;
  assign IF_ID_Valid   = r_valid;
  assign FetchWait     = !IMemReady && !w_redirect;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_flushCnt;
  logic        w_stallCycle;

  assign w_stallCycle = !w_redirect && (!PC_IFWrite || !IMemReady);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= 32'd0;
      r_flushCnt <= 32'd0;
    end else begin
      if (w_stallCycle && (r_stallCnt != 32'hFFFF_FFFF))
        r_stallCnt <= r_stallCnt + 32'd1;
      if (w_redirect && (r_flushCnt != 32'hFFFF_FFFF))
        r_flushCnt <= r_flushCnt + 32'd1;
    end
  end

  assign IfStallCnt = r_stallCnt;
  assign IfFlushCnt = r_flushCnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage_ifid.sv
// ============================================================================
// Module   : tb_if_stage_ifid
// Purpose  : Directed self-checking bench for if_stage_ifid.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage_ifid;

  localparam logic [31:0] c_resetPc = 32'h0000_3000;
  localparam logic [31:0] c_nop     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_IFWrite;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpTaken;
  logic [31:0] JumpTarget;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemReady;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        FetchWait;
`ifdef IF_PERF_CNT_EN
  logic [31:0] IfStallCnt;
  logic [31:0] IfFlushCnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_stage_ifid #(
    .RESET_PC  (c_resetPc),
    .NOP_INSTR (c_nop)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_IFWrite    (PC_IFWrite),
    .BranchTaken   (BranchTaken),
    .BranchTarget  (BranchTarget),
    .JumpTaken     (JumpTaken),
    .JumpTarget    (JumpTarget),
    .IMemAddr      (IMemAddr),
    .IMemData      (IMemData),
    .IMemReady     (IMemReady),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PC      (IF_ID_PC),
    .IF_ID_PCPlus4 (IF_ID_PCPlus4),
    .IF_ID_Valid   (IF_ID_Valid),
    .FetchWait     (FetchWait)
`ifdef IF_PERF_CNT_EN
    ,
    .IfStallCnt    (IfStallCnt),
    .IfFlushCnt    (IfFlushCnt)
`endif
  );

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    PC_IFWrite   = 1'b1;
    BranchTaken  = 1'b0;
    BranchTarget = 32'd0;
    JumpTaken    = 1'b0;
    JumpTarget   = 32'd0;
    IMemReady    = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    IMemData = 32'hFFFF_FFFF;
    step();
    step();
    tests++; if (IMemAddr !== 32'h0000_3000) begin fails++; $display("FAIL reset_addr: got %h want %h", IMemAddr, 32'h0000_3000); end
    tests++; if (IF_ID_Valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", IF_ID_Valid); end
    tests++; if (IF_ID_Instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", IF_ID_Instr); end
    tests++; if (IF_ID_PC !== 32'h0 || IF_ID_PCPlus4 !== 32'h0) begin fails++; $display("FAIL reset_pcs: got %h/%h want 0/0", IF_ID_PC, IF_ID_PCPlus4); end
    rst = 1'b0;
    IMemData = 32'h1111_1111;
    step();
    tests++; if (IF_ID_PC !== 32'h0000_3000) begin fails++; $display("FAIL first_fetch_pc: got %h want 00003000", IF_ID_PC); end
    tests++; if (IMemAddr !== 32'h0000_3004) begin fails++; $display("FAIL first_fetch_addr: got %h want 00003004", IMemAddr); end
    tests++; if (IF_ID_Instr !== 32'h1111_1111 || IF_ID_Valid !== 1'b1) begin fails++; $display("FAIL first_fetch_instr: got %h/%b want 11111111/1", IF_ID_Instr, IF_ID_Valid); end
  endtask

  task automatic test_sequential();
    JumpTaken  = 1'b1;
    JumpTarget = 32'h0000_0000;
    step();
    JumpTaken = 1'b0;
    tests++; if (IMemAddr !== 32'h0 || IF_ID_Valid !== 1'b0) begin fails++; $display("FAIL jump_to_zero: addr %h valid %b want 0/0", IMemAddr, IF_ID_Valid); end
    for (int k = 0; k < 4; k++) begin
      IMemData = 32'h2000_0000 + k;
      step();
      tests++;
      if (IF_ID_PC !== 32'(4 * k) || IF_ID_PCPlus4 !== 32'(4 * k + 4) ||
          IF_ID_Valid !== 1'b1 || IF_ID_Instr !== 32'h2000_0000 + k) begin
        fails++;
        $display("FAIL seq_fetch%0d: pc %h pc4 %h v %b instr %h want %h %h 1 %h",
                 k, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Instr,
                 32'(4 * k), 32'(4 * k + 4), 32'h2000_0000 + k);
      end
    end
  endtask

  task automatic test_load_use();
    IMemData = 32'h8C22_0000;
    step();
    tests++; if (IF_ID_Instr !== 32'h8C22_0000 || IF_ID_PC !== 32'h10) begin fails++; $display("FAIL lw_fetch: got %h@%h want 8c220000@00000010", IF_ID_Instr, IF_ID_PC); end
    PC_IFWrite = 1'b0;
    IMemData   = 32'hDEAD_BEEF;
    step();
    tests++;
    if (IF_ID_Instr !== 32'h8C22_0000 || IF_ID_PC !== 32'h10 ||
        IF_ID_PCPlus4 !== 32'h14 || IF_ID_Valid !== 1'b1 || IMemAddr !== 32'h14) begin
      fails++;
      $display("FAIL stall_hold: instr %h pc %h pc4 %h v %b addr %h want 8c220000 10 14 1 14",
               IF_ID_Instr, IF_ID_PC, IF_ID_PCPlus4, IF_ID_Valid, IMemAddr);
    end
    PC_IFWrite = 1'b1;
    IMemData   = 32'h0001_0020;
    step();
    tests++; if (IF_ID_PC !== 32'h14 || IMemAddr !== 32'h18 || IF_ID_Instr !== 32'h0001_0020) begin fails++; $display("FAIL stall_resume: pc %h addr %h instr %h want 14 18 00010020", IF_ID_PC, IMemAddr, IF_ID_Instr); end
  endtask

  task automatic test_redirect_stall();
    PC_IFWrite   = 1'b0;
    IMemReady    = 1'b0;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h0000_0103;
    JumpTaken    = 1'b1;
    JumpTarget   = 32'h0000_0200;
    #1;
    tests++; if (FetchWait !== 1'b0) begin fails++; $display("FAIL fetchwait_redirect: got %b want 0", FetchWait); end
    step();
    tests++; if (IMemAddr !== 32'h0000_0100) begin fails++; $display("FAIL branch_wins: addr %h want 00000100", IMemAddr); end
    tests++;
    if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== c_nop || IF_ID_PC !== 32'h0 || IF_ID_PCPlus4 !== 32'h0) begin
      fails++;
      $display("FAIL redirect_bubble: v %b instr %h pc %h pc4 %h want 0 0 0 0",
               IF_ID_Valid, IF_ID_Instr, IF_ID_PC, IF_ID_PCPlus4);
    end
    BranchTaken = 1'b0;
    JumpTarget  = 32'h0000_0042;
    step();
    JumpTaken  = 1'b0;
    tests++; if (IMemAddr !== 32'h0000_0040) begin fails++; $display("FAIL back_to_back_jump: addr %h want 00000040", IMemAddr); end
  endtask

  task automatic test_mem_wait();
    PC_IFWrite = 1'b1;
    IMemReady  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (FetchWait !== 1'b1) begin fails++; $display("FAIL fetchwait%0d: got %b want 1", k, FetchWait); end
      step();
      tests++; if (IMemAddr !== 32'h40 || IF_ID_Valid !== 1'b0 || IF_ID_Instr !== c_nop) begin fails++; $display("FAIL mem_wait%0d: addr %h v %b instr %h want 40 0 0", k, IMemAddr, IF_ID_Valid, IF_ID_Instr); end
    end
    PC_IFWrite = 1'b0;
    IMemReady  = 1'b1;
    IMemData   = 32'hAAAA_5555;
    step();
    tests++; if (IF_ID_Valid !== 1'b0 || IMemAddr !== 32'h40) begin fails++; $display("FAIL stall_bubble_hold: v %b addr %h want 0 40", IF_ID_Valid, IMemAddr); end
    PC_IFWrite = 1'b1;
    step();
    tests++;
    if (IF_ID_PC !== 32'h40 || IF_ID_Valid !== 1'b1 || IF_ID_Instr !== 32'hAAAA_5555 || IMemAddr !== 32'h44) begin
      fails++;
      $display("FAIL mem_ready: pc %h v %b instr %h addr %h want 40 1 aaaa5555 44",
               IF_ID_PC, IF_ID_Valid, IF_ID_Instr, IMemAddr);
    end
  endtask

  task automatic test_wrap();
    JumpTaken  = 1'b1;
    JumpTarget = 32'hFFFF_FFFC;
    step();
    JumpTaken = 1'b0;
    IMemData  = 32'h1234_5678;
    step();
    tests++;
    if (IMemAddr !== 32'h0 || IF_ID_PC !== 32'hFFFF_FFFC || IF_ID_PCPlus4 !== 32'h0) begin
      fails++;
      $display("FAIL pc_wrap: addr %h pc %h pc4 %h want 0 fffffffc 0", IMemAddr, IF_ID_PC, IF_ID_PCPlus4);
    end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (IfStallCnt !== 32'd0 || IfFlushCnt !== 32'd0) begin fails++; $display("FAIL perf_reset: %0d/%0d want 0/0", IfStallCnt, IfFlushCnt); end
    step();
    PC_IFWrite = 1'b0;
    step();
    PC_IFWrite = 1'b1;
    IMemReady  = 1'b0;
    step();
    IMemReady   = 1'b1;
    BranchTaken = 1'b1;
    PC_IFWrite  = 1'b0;
    BranchTarget = 32'h0000_0080;
    step();
    BranchTaken = 1'b0;
    PC_IFWrite  = 1'b1;
    step();
    tests++; if (IfStallCnt !== 32'd2) begin fails++; $display("FAIL perf_stall: got %0d want 2", IfStallCnt); end
    tests++; if (IfFlushCnt !== 32'd1) begin fails++; $display("FAIL perf_flush: got %0d want 1", IfFlushCnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_load_use();
    test_redirect_stall();
    test_mem_wait();
    test_wrap();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
